uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `NREQ` byte producers (ALU result path, status/echo path, debug). It grants one requester at a time and latches that requester's byte. It issues a single-cycle start to the transmitter, then holds off further grants until the transmitter reports done. A watchdog returns the arbiter to idle and flags an error if done never arrives. It sits between the producers and `uart_tx`, sharing `i_clk`/`i_reset` with it.

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART TX arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_WAIT  = 2'b10
  } arb_state_e;

  localparam int UART_NBITS_DATA = 8;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_sel,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [IW:0]   sum;
  logic [IW-1:0] cidx;
  logic          found;

  always_comb begin
    o_sel = '0;
    o_idx = '0;
    found = 1'b0;
    sum   = '0;
    cidx  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      sum = {1'b0, i_last} + (IW+1)'(off);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      cidx = sum[IW-1:0];
      if (!found && i_req[cidx]) begin
        found       = 1'b1;
        o_sel[cidx] = 1'b1;
        o_idx       = cidx;
      end
    end
  end

  assign o_any = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte producers, with a
// watchdog that aborts a frame whose done never arrives.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NBITS_DATA  = UART_NBITS_DATA,
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NREQ-1:0]            i_req,
  input  logic [NREQ*NBITS_DATA-1:0] i_data,
  output logic [NREQ-1:0]            o_grant,
  output logic                       o_tx_start,
  output logic [NBITS_DATA-1:0]      o_tx_data,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int          IW   = idx_w(NREQ);
  localparam int          CW   = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

  arb_state_e            state_q, state_d;
  logic [NREQ-1:0]       grant_q, grant_d;
  logic                  tx_start_q, tx_start_d;
  logic [NBITS_DATA-1:0] tx_data_q, tx_data_d;
  logic [IW-1:0]         last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [NREQ-1:0]       pick_sel;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic [NBITS_DATA-1:0] req_byte [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign req_byte[k] = i_data[k*NBITS_DATA +: NBITS_DATA];
  end

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req  (i_req),
    .i_last (last_q),
    .o_sel  (pick_sel),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_sel;
          tx_data_d  = req_byte[pick_idx];
          last_d     = pick_idx;
          tx_start_d = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done wins over a coincident watchdog expiry
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TERM) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_START) || (state_d == ST_WAIT);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= IW'(NREQ - 1);
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle compare against a transfer-lifetime model
// plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

  localparam int NB = 8;
  localparam int NR = 4;
  localparam int TO = 50;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NR-1:0]         req;
  logic [NR-1:0][NB-1:0] dbytes;
  logic                  done;
  logic [NR-1:0]         grant;
  logic                  start;
  logic [NB-1:0]         txd;
  logic                  busy, tmo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NBITS_DATA(NB), .NREQ(NR), .TIMEOUT_CYC(TO)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req      (req),
    .i_data     (dbytes),
    .o_grant    (grant),
    .o_tx_start (start),
    .o_tx_data  (txd),
    .i_tx_done  (done),
    .o_busy     (busy),
    .o_timeout  (tmo)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transfer lives from its grant edge; age 1 is the start cycle,
  // age >= 2 is waiting with the watchdog at age-2.
  logic [NR-1:0] e_grant;
  logic          e_start, e_busy, e_tmo;
  logic [NB-1:0] e_data;
  int            m_last, m_age;
  bit            m_live;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin : model
    int nl, na;
    bit nlive;
    logic [NR-1:0] g;
    logic s, b, t;
    logic [NB-1:0] d;
    nl = m_last; na = m_age; nlive = m_live;
    g = '0; s = 1'b0; t = 1'b0; b = e_busy; d = e_data;
    if (rst) begin
      nl = NR - 1; na = 0; nlive = 0; b = 1'b0; d = '0;
    end else if (!m_live) begin
      if (req != '0) begin
        for (int st = 1; st <= NR; st++)
          if (req[(m_last + st) % NR]) begin nl = (m_last + st) % NR; break; end
        g[nl] = 1'b1; d = dbytes[nl]; s = 1'b1; b = 1'b1; nlive = 1; na = 1;
      end
    end else begin
      if (m_age >= 2 && done) begin
        nlive = 0; b = 1'b0;
      end else if (m_age >= 2 && m_age - 2 == TO - 1) begin
        nlive = 0; b = 1'b0; t = 1'b1;
      end
      na = m_age + 1;
    end
    m_last <= nl; m_age <= na; m_live <= nlive;
    e_grant <= g; e_start <= s; e_busy <= b; e_tmo <= t; e_data <= d;
    m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_grant", 32'(grant), 32'(e_grant));
      chk("cyc_start", 32'(start), 32'(e_start));
      chk("cyc_data",  32'(txd),   32'(e_data));
      chk("cyc_busy",  32'(busy),  32'(e_busy));
      chk("cyc_tmo",   32'(tmo),   32'(e_tmo));
    end
  end

  task automatic wait_start();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (start) ok = 1'b1;
    end
    chk("start_seen", 32'(ok), 32'd1);
  endtask

  task automatic pulse_done(input int gap);
    repeat (gap) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [NB-1:0] rot_exp [5];
  int            k;
  bit            got;

  initial begin
    rot_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    rst = 1'b1; req = '0; dbytes = '0; done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_txd",   32'(txd),   32'd0);

    // single request on requester 2
    dbytes[2] = 8'h5A; req = 4'b0100;
    @(negedge clk);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_start", 32'(start), 32'd1);
    chk("single_data",  32'(txd),   32'h5A);
    req = '0;
    @(negedge clk);
    chk("single_start_drop", 32'(start), 32'd0);
    pulse_done(4);
    chk("single_busy_fall", 32'(busy), 32'd0);

    // saturation rotation after reset
    do_reset();
    dbytes = {8'h13, 8'h12, 8'h11, 8'h10}; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start();
      chk("rot_data", 32'(txd), 32'(rot_exp[i]));
      if (i == 4) req = '0;
      pulse_done(2);
    end

    // requester 3 arrives mid-frame, 1 re-requests
    dbytes[1] = 8'h21; dbytes[3] = 8'h23; req = 4'b0010;
    wait_start();
    chk("late_first", 32'(grant), 32'h2);
    req = 4'b1010;
    pulse_done(5);
    wait_start();
    chk("late_second", 32'(grant), 32'h8);
    chk("late_second_data", 32'(txd), 32'h23);
    pulse_done(2);
    wait_start();
    chk("late_third", 32'(grant), 32'h2);
    req = '0;
    pulse_done(2);

    // watchdog with done never arriving
    dbytes[0] = 8'h77; req = 4'b0001;
    wait_start();
    req = '0; k = 0; got = 0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(negedge clk);
      if (tmo) begin got = 1; k = i; end
    end
    chk("tmo_latency", 32'(k), 32'd51);
    chk("tmo_busy", 32'(busy), 32'd0);
    req = 4'b0100;
    wait_start();
    chk("post_tmo_grant", 32'(grant), 32'h4);
    req = '0;
    pulse_done(3);

    // done coinciding with the terminal count
    req = 4'b0001;
    wait_start();
    req = '0;
    repeat (50) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("coinc_tmo",  32'(tmo),  32'd0);
    chk("coinc_busy", 32'(busy), 32'd0);

    // reset in the middle of a wait
    req = 4'b1111;
    wait_start();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_start", 32'(start), 32'd0);
    chk("midrst_txd",   32'(txd),   32'd0);
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_tmo",   32'(tmo),   32'd0);
    rst = 1'b0;
    wait_start();
    chk("midrst_first", 32'(grant), 32'h1);
    req = '0;
    pulse_done(2);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
